// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one async FIFO write port among NUM_REQ wr_clk-domain requesters.
// Define FIFO_ARB_BURST_EN to enable locked bursts of up to MAX_BURST words per grant.
module fifo_wr_arbiter #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned MAX_BURST = 8,
  localparam int unsigned ID_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                       wr_clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*WIDTH-1:0]   req_data,
  input  logic [NUM_REQ-1:0]         req_last,
  output logic [NUM_REQ-1:0]         gnt,
  input  logic                       fifo_full,
  output logic                       fifo_wr_en,
  output logic [WIDTH-1:0]           fifo_write_data,
  output logic [ID_W-1:0]            owner_id,
  output logic                       locked
);

  logic [ID_W-1:0] rr_q, rr_d;
  logic [ID_W-1:0] owner_q, owner_d;
  logic [ID_W-1:0] arb_idx, cand, sel;
  logic            arb_found, sel_vld, xfer;

`ifdef FIFO_ARB_BURST_EN
  localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

  typedef enum logic [0:0] {ARB = 1'b0, LOCK = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;

  assign cnt_inc = cnt_q + CNT_W'(1);
  assign locked  = (state_q == LOCK);

  always_ff @(posedge wr_clk) begin
    if (rst) begin
      state_q <= ARB;
      cnt_q   <= '0;
      rr_q    <= ID_W'(NUM_REQ - 1);
      owner_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rr_q    <= rr_d;
      owner_q <= owner_d;
    end
  end
`else
  logic unused_c;

  // Burst inputs have no function when bursts are compiled out
  assign unused_c = (^req_last) ^ (MAX_BURST == 0);
  assign locked   = 1'b0;

  always_ff @(posedge wr_clk) begin
    if (rst) begin
      rr_q    <= ID_W'(NUM_REQ - 1);
      owner_q <= '0;
    end else begin
      rr_q    <= rr_d;
      owner_q <= owner_d;
    end
  end
`endif

  assign owner_id = owner_q;

  // Selection, zero-latency grant/write path and next-state logic
  always_comb begin
    rr_d            = rr_q;
    owner_d         = owner_q;
    gnt             = '0;
    fifo_wr_en      = 1'b0;
    fifo_write_data = '0;
    arb_found       = 1'b0;
    arb_idx         = '0;
    cand            = '0;
`ifdef FIFO_ARB_BURST_EN
    state_d         = state_q;
    cnt_d           = cnt_q;
`endif

    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = ID_W'((32'(rr_q) + k) % NUM_REQ);
      if (!arb_found && req[cand]) begin
        arb_found = 1'b1;
        arb_idx   = cand;
      end
    end

`ifdef FIFO_ARB_BURST_EN
    if (state_q == LOCK) begin
      sel     = owner_q;
      sel_vld = req[owner_q];
    end else begin
      sel     = arb_idx;
      sel_vld = arb_found;
    end
`else
    sel     = arb_idx;
    sel_vld = arb_found;
`endif

    xfer = sel_vld && !fifo_full && !rst;

    if (xfer) begin
      gnt[sel]   = 1'b1;
      fifo_wr_en = 1'b1;
      owner_d    = sel;
    end

    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (gnt[i]) fifo_write_data = fifo_write_data | req_data[i*WIDTH +: WIDTH];
    end

`ifdef FIFO_ARB_BURST_EN
    case (state_q)
      ARB: begin
        if (xfer) begin
          if (!req_last[sel] && (MAX_BURST > 1)) begin
            state_d = LOCK;
            cnt_d   = CNT_W'(1);
          end else begin
            rr_d = sel;
          end
        end
      end
      LOCK: begin
        if (xfer) begin
          if (req_last[owner_q] || (cnt_inc == CNT_W'(MAX_BURST))) begin
            state_d = ARB;
            cnt_d   = '0;
            rr_d    = owner_q;
          end else begin
            cnt_d = cnt_inc;
          end
        end else if (!req[owner_q] && !fifo_full) begin
          // Owner withdrew: release the lock with no grant this cycle
          state_d = ARB;
          cnt_d   = '0;
          rr_d    = owner_q;
        end
      end
      default: state_d = ARB;
    endcase
`else
    if (xfer) rr_d = sel;
`endif
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: stimulus pushes hand-computed expectations, a monitor compares mid-cycle.
// Burst scenarios are built only when FIFO_ARB_BURST_EN is defined.
module tb_fifo_wr_arbiter;

  logic        wr_clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  gnt;
  logic        fifo_full;
  logic        fifo_wr_en;
  logic [7:0]  fifo_write_data;
  logic [1:0]  owner_id;
  logic        locked;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [3:0] gnt;
    logic       wr_en;
    logic [7:0] data;
    logic [1:0] owner;
    logic       locked;
  } exp_t;

  exp_t sb[$];

  fifo_wr_arbiter #(.NUM_REQ(4), .WIDTH(8), .MAX_BURST(8)) dut (
    .wr_clk          (wr_clk),
    .rst             (rst),
    .req             (req),
    .req_data        (req_data),
    .req_last        (req_last),
    .gnt             (gnt),
    .fifo_full       (fifo_full),
    .fifo_wr_en      (fifo_wr_en),
    .fifo_write_data (fifo_write_data),
    .owner_id        (owner_id),
    .locked          (locked)
  );

  always #5 wr_clk = ~wr_clk;

  // Requester words: 0 -> A1, 1 -> B2, 2 -> C3, 3 -> D4
  function automatic logic [7:0] exp_data(input logic [3:0] g);
    case (g)
      4'b0001: return 8'hA1;
      4'b0010: return 8'hB2;
      4'b0100: return 8'hC3;
      4'b1000: return 8'hD4;
      default: return 8'h00;
    endcase
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // Monitor: pop one expectation per cycle and compare mid-cycle
  always @(negedge wr_clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check("gnt",        8'(gnt),        8'(e.gnt));
      check("fifo_wr_en", 8'(fifo_wr_en), 8'(e.wr_en));
      check("write_data", fifo_write_data, e.data);
      check("owner_id",   8'(owner_id),   8'(e.owner));
      check("locked",     8'(locked),     8'(e.locked));
    end
  end

  task automatic step(input logic rs, input logic [3:0] r, input logic [3:0] l, input logic f,
                      input logic [3:0] eg, input logic [1:0] eo, input logic el);
    exp_t e;
    rst       = rs;
    req       = r;
    req_last  = l;
    fifo_full = f;
    e.gnt     = eg;
    e.wr_en   = (eg != 4'b0000);
    e.data    = exp_data(eg);
    e.owner   = eo;
    e.locked  = el;
    sb.push_back(e);
    @(posedge wr_clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    req       = '0;
    req_last  = '0;
    fifo_full = 1'b0;
    req_data  = {8'hD4, 8'hC3, 8'hB2, 8'hA1};
    @(posedge wr_clk);
    #1;

    // Reset held with all requesting, then full rotation from requester 0
    step(1, 4'b1111, 4'b0000, 0, 4'b0000, 2'd0, 0);
    step(1, 4'b1111, 4'b0000, 0, 4'b0000, 2'd0, 0);
    step(0, 4'b1111, 4'b1111, 0, 4'b0001, 2'd0, 0);
    step(0, 4'b1111, 4'b1111, 0, 4'b0010, 2'd0, 0);
    step(0, 4'b1111, 4'b1111, 0, 4'b0100, 2'd1, 0);
    step(0, 4'b1111, 4'b1111, 0, 4'b1000, 2'd2, 0);
    step(0, 4'b1111, 4'b1111, 0, 4'b0001, 2'd3, 0);

    // FIFO full stalls everything; pointer restarts at 0 after reset
    step(1, 4'b0000, 4'b1111, 0, 4'b0000, 2'd0, 0);
    step(1, 4'b0000, 4'b1111, 0, 4'b0000, 2'd0, 0);
    for (int i = 0; i < 5; i++) step(0, 4'b0101, 4'b1111, 1, 4'b0000, 2'd0, 0);
    step(0, 4'b0101, 4'b1111, 0, 4'b0001, 2'd0, 0);
    step(0, 4'b0101, 4'b1111, 0, 4'b0100, 2'd0, 0);
    step(0, 4'b0101, 4'b1111, 1, 4'b0000, 2'd2, 0);
    step(0, 4'b0101, 4'b1111, 0, 4'b0001, 2'd2, 0);

    // Lone requester 3, then wrap-around to requester 0
    step(1, 4'b0000, 4'b1111, 0, 4'b0000, 2'd0, 0);
    step(1, 4'b0000, 4'b1111, 0, 4'b0000, 2'd0, 0);
    step(0, 4'b1000, 4'b1111, 0, 4'b1000, 2'd0, 0);
    step(0, 4'b1000, 4'b1111, 0, 4'b1000, 2'd3, 0);
    step(0, 4'b1000, 4'b1111, 0, 4'b1000, 2'd3, 0);
    step(0, 4'b1001, 4'b1111, 0, 4'b0001, 2'd3, 0);
    step(0, 4'b1001, 4'b1111, 0, 4'b1000, 2'd0, 0);
    step(0, 4'b0000, 4'b1111, 0, 4'b0000, 2'd3, 0);
    step(0, 4'b0110, 4'b1111, 0, 4'b0010, 2'd3, 0);
    step(0, 4'b0000, 4'b1111, 0, 4'b0000, 2'd1, 0);

`ifdef FIFO_ARB_BURST_EN
    // Burst of three ended by req_last, then requester 1
    step(1, 4'b0000, 4'b0000, 0, 4'b0000, 2'd1, 0);
    step(1, 4'b0000, 4'b0000, 0, 4'b0000, 2'd0, 0);
    step(0, 4'b0011, 4'b0000, 0, 4'b0001, 2'd0, 0);
    step(0, 4'b0011, 4'b0000, 0, 4'b0001, 2'd0, 1);
    step(0, 4'b0011, 4'b0001, 0, 4'b0001, 2'd0, 1);
    step(0, 4'b0011, 4'b0010, 0, 4'b0010, 2'd0, 0);
    step(0, 4'b0000, 4'b0000, 0, 4'b0000, 2'd1, 0);

    // Burst capped at MAX_BURST=8, then owner withdraws from a fresh lock
    step(1, 4'b0000, 4'b0000, 0, 4'b0000, 2'd1, 0);
    step(1, 4'b0000, 4'b0000, 0, 4'b0000, 2'd0, 0);
    step(0, 4'b0110, 4'b0000, 0, 4'b0010, 2'd0, 0);
    for (int i = 0; i < 7; i++) step(0, 4'b0110, 4'b0000, 0, 4'b0010, 2'd1, 1);
    step(0, 4'b0110, 4'b0000, 0, 4'b0100, 2'd1, 0);
    step(0, 4'b0010, 4'b0000, 0, 4'b0000, 2'd2, 1);
    step(0, 4'b0000, 4'b0000, 0, 4'b0000, 2'd2, 0);

    // Reset during the second word of a burst drops the lock
    step(1, 4'b0000, 4'b0000, 0, 4'b0000, 2'd2, 0);
    step(0, 4'b0011, 4'b0000, 0, 4'b0001, 2'd0, 0);
    step(1, 4'b0011, 4'b0000, 0, 4'b0000, 2'd0, 1);
    step(0, 4'b0011, 4'b0011, 0, 4'b0001, 2'd0, 0);
    step(0, 4'b0011, 4'b0011, 0, 4'b0010, 2'd0, 0);
`endif

    step(0, 4'b0000, 4'b0000, 0, 4'b0000, owner_id, locked);
    @(posedge wr_clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
